// File: rtl/gpu_block_dispatcher.sv
// Kernel-launch scheduler: splits a thread count into fixed-size blocks and hands
// them, one per cycle, to the lowest-indexed idle core until every block retires.
module gpu_block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_W          = 8
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [THREAD_W-1:0]                                   thread_count,
  input  logic [NUM_CORES-1:0]                                  core_done,
  output logic [NUM_CORES-1:0]                                  core_start,
  output logic [NUM_CORES*THREAD_W-1:0]                         core_block_id,
  output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]    core_thread_count,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int CNT_W   = LOG_TPB + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DISPATCH,
    S_DONE
  } state_e;

  state_e                        r_state;
  state_e                        w_next_state;

  logic [THREAD_W-1:0]           r_thread_count;
  logic [THREAD_W-1:0]           r_total_blocks;
  logic [THREAD_W-1:0]           r_next_block;
  logic [THREAD_W-1:0]           r_blocks_done;
  logic [NUM_CORES-1:0]          r_core_busy;
  logic [NUM_CORES-1:0]          r_core_start;
  logic [NUM_CORES*THREAD_W-1:0] r_core_block_id;
  logic [NUM_CORES*CNT_W-1:0]    r_core_thread_count;

  logic [LOG_TPB-1:0]            w_remainder;
  logic [THREAD_W-1:0]           w_total_blocks;
  logic [NUM_CORES-1:0]          w_idle;
  logic [NUM_CORES-1:0]          w_grant;
  logic [NUM_CORES-1:0]          w_retire;
  logic [THREAD_W-1:0]           w_retire_cnt;
  logic                          w_in_dispatch;
  logic                          w_dispatch;
  logic                          w_last_block;
  logic [CNT_W-1:0]              w_block_threads;

  // Ceiling divide by a power of two: whole blocks plus one if any threads remain.
  assign w_remainder    = r_thread_count[LOG_TPB-1:0];
  assign w_total_blocks = (r_thread_count >> LOG_TPB) + THREAD_W'(|w_remainder);

  assign w_in_dispatch = (r_state == S_DISPATCH);
  assign w_idle        = ~r_core_busy;
  assign w_dispatch    = w_in_dispatch && (r_next_block < r_total_blocks) && (|w_idle);

  // Lowest set bit of the idle mask picks the core; a core freed this cycle is
  // still marked busy here, so it cannot be redispatched until the next cycle.
  assign w_grant  = w_idle & (~w_idle + NUM_CORES'(1)) & {NUM_CORES{w_dispatch}};
  assign w_retire = core_done & r_core_busy & {NUM_CORES{w_in_dispatch}};

  assign w_last_block    = (r_next_block == r_total_blocks - THREAD_W'(1));
  assign w_block_threads = (w_last_block && (w_remainder != '0))
                         ? {1'b0, w_remainder}
                         : CNT_W'(THREADS_PER_BLOCK);

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_retire_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_retire_cnt = w_retire_cnt + THREAD_W'(w_retire[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_next_state = (w_total_blocks == '0) ? S_DONE : S_DISPATCH;
      end
      S_DISPATCH: begin
        if (r_blocks_done == r_total_blocks) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_LOAD, S_DISPATCH: busy = 1'b1;
      S_DONE:             done = 1'b1;
      default:            ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_thread_count      <= '0;
      r_total_blocks      <= '0;
      r_next_block        <= '0;
      r_blocks_done       <= '0;
      r_core_busy         <= '0;
      r_core_start        <= '0;
      r_core_block_id     <= '0;
      r_core_thread_count <= '0;
    end else begin
      r_core_start <= w_grant;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) r_thread_count <= thread_count;
        end
        S_LOAD: begin
          r_total_blocks <= w_total_blocks;
          r_next_block   <= '0;
          r_blocks_done  <= '0;
          r_core_busy    <= '0;
        end
        S_DISPATCH: begin
          r_core_busy   <= (r_core_busy & ~w_retire) | w_grant;
          r_blocks_done <= r_blocks_done + w_retire_cnt;
          if (w_dispatch) r_next_block <= r_next_block + THREAD_W'(1);
        end
        default: ;
      endcase

      // Block descriptor is held per core until that core's next dispatch.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_grant[i]) begin
          r_core_block_id[i*THREAD_W +: THREAD_W] <= r_next_block;
          r_core_thread_count[i*CNT_W +: CNT_W]   <= w_block_threads;
        end
      end
    end
  end

  assign core_start        = r_core_start;
  assign core_block_id     = r_core_block_id;
  assign core_thread_count = r_core_thread_count;

endmodule
